// File: rtl/datapath_pkg.sv
// Shared datapath definitions: instruction field positions, widths and the default bubble word.
package datapath_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned DS_BIT    = 29;
  localparam int unsigned ALUOP_LSB = 26;
  localparam int unsigned WS_LSB    = 21;
  localparam int unsigned RS1_LSB   = 16;
  localparam int unsigned RS2_LSB   = 11;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned REG_SEL_W = 5;
  localparam int unsigned ALUOP_W   = 3;

  // WS=0 is treated as discard by the datapath, so all-zero is a safe bubble.
  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic                 ds;
    logic [ALUOP_W-1:0]   aluop;
    logic [REG_SEL_W-1:0] ws;
    logic [REG_SEL_W-1:0] rs1;
    logic [REG_SEL_W-1:0] rs2;
    logic [IMM_W-1:0]     imm;
  } instr_fields_t;

endpackage

// File: rtl/instr_encode_issue_if.sv
// Field-bundle input handshake, pipeline controls and stage-1 issue outputs of the encoder.
interface instr_encode_issue_if #(
  parameter int unsigned DEPTH = 4
);
  import datapath_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [REG_SEL_W-1:0] in_ws;
  logic [REG_SEL_W-1:0] in_rs1;
  logic [REG_SEL_W-1:0] in_rs2;
  logic [IMM_W-1:0]     in_imm;
  logic                 in_ds;
  logic [ALUOP_W-1:0]   in_aluop;
  logic                 stall;
  logic                 flush;
  logic [INSTR_W-1:0]   InstrOut;
  logic                 out_valid;
  logic [CNT_W-1:0]     count;

  modport master (
    output in_valid, in_ws, in_rs1, in_rs2, in_imm, in_ds, in_aluop, stall, flush,
    input  in_ready, InstrOut, out_valid, count
  );

  modport slave (
    input  in_valid, in_ws, in_rs1, in_rs2, in_imm, in_ds, in_aluop, stall, flush,
    output in_ready, InstrOut, out_valid, count
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational encoder from decoded instruction fields to the 32-bit stage-1 word.
module instr_pack
  import datapath_pkg::*;
(
  input  instr_fields_t      fields,
  output logic [INSTR_W-1:0] word
);

  always_comb begin
    word                            = '0;
    word[DS_BIT]                    = fields.ds;
    word[ALUOP_LSB +: ALUOP_W]      = fields.aluop;
    word[WS_LSB +: REG_SEL_W]       = fields.ws;
    word[RS1_LSB +: REG_SEL_W]      = fields.rs1;
    // Low half carries either the immediate or R3 left-justified; never both.
    if (fields.ds) begin
      word[IMM_W-1:0]               = fields.imm;
    end else begin
      word[RS2_LSB +: REG_SEL_W]    = fields.rs2;
    end
  end

endmodule

// File: rtl/instr_encode_issue.sv
// Encodes accepted field bundles, buffers them in a small FIFO and issues one word per
// unstalled cycle into the stage-1 instruction register, bubbling NOP_WORD when empty.
module instr_encode_issue
  import datapath_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  instr_encode_issue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  instr_fields_t      fields;
  logic [INSTR_W-1:0] packed_word;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  logic full, empty, push, pop;

  assign fields = '{
    ds:    bus.in_ds,
    aluop: bus.in_aluop,
    ws:    bus.in_ws,
    rs1:   bus.in_rs1,
    rs2:   bus.in_rs2,
    imm:   bus.in_imm
  };

  instr_pack u_instr_pack (
    .fields (fields),
    .word   (packed_word)
  );

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Refusing pushes when full, regardless of a same-cycle pop, keeps in_ready off the stall path.
  assign push = bus.in_valid && !full && !bus.flush;
  assign pop  = !bus.flush && !bus.stall && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    valid_d  = valid_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      instr_d  = NOP_WORD;
      valid_d  = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      if (!bus.stall) begin
        if (!empty) begin
          instr_d = mem_q[rd_ptr_q];
          valid_d = 1'b1;
        end else begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= packed_word;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.InstrOut  = instr_q;
  assign bus.out_valid = valid_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_instr_encode_issue.sv
// Directed bench for instr_encode_issue: a scoreboard queue of expected issue words is fed at
// push time and drained as the issue register updates.
module tb_instr_encode_issue;
  import datapath_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_encode_issue_if #(.DEPTH(DEPTH)) bus ();

  instr_encode_issue #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_instr = NOP;
  logic        exp_valid = 1'b0;

  function automatic logic [31:0] enc(input logic ds, input logic [2:0] aluop,
                                      input logic [4:0] ws, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [15:0] imm);
    logic [15:0] low;
    low = ds ? imm : {rs2, 11'b0};
    return {2'b00, ds, aluop, ws, rs1, low};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic ds, input logic [2:0] aluop,
                       input logic [4:0] ws, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [15:0] imm);
    bus.in_valid = valid;
    bus.in_ds    = ds;
    bus.in_aluop = aluop;
    bus.in_ws    = ws;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
  endtask

  task automatic drive_rand();
    drive(1'b1, 1'($urandom), 3'($urandom), 5'($urandom_range(1, 31)), 5'($urandom),
          5'($urandom), 16'($urandom));
  endtask

  function automatic logic [31:0] cur_word();
    return enc(bus.in_ds, bus.in_aluop, bus.in_ws, bus.in_rs1, bus.in_rs2, bus.in_imm);
  endfunction

  // One clock: predict the push and issue outcome, then compare every output #1 after the edge.
  task automatic step();
    logic        push_exp;
    logic [31:0] w;
    push_exp = bus.in_valid && !bus.flush && !rst && (sb.size() < DEPTH);
    w        = cur_word();
    if (!rst) chk("in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
    @(posedge clk);
    #1;
    if (rst || bus.flush) begin
      sb.delete();
      exp_instr = NOP;
      exp_valid = 1'b0;
    end else if (!bus.stall) begin
      if (sb.size() > 0) begin
        exp_instr = sb.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_instr = NOP;
        exp_valid = 1'b0;
      end
    end
    if (push_exp) sb.push_back(w);
    chk("instr_out", bus.InstrOut, exp_instr);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    chk("count", 32'(bus.count), 32'(sb.size()));
  endtask

  logic [31:0] a_w, b_w, x_w, w4;

  initial begin
    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0);
    step();
    step();
    rst = 1'b0;
    chk("reset_instr", bus.InstrOut, 32'h0000_0000);
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_ready", 32'(bus.in_ready), 32'd1);

    // Immediate encode, two edges from push to issue.
    drive(1'b1, 1'b1, 3'b010, 5'd3, 5'd1, 5'd0, 16'h00FF);
    step();
    bus.in_valid = 1'b0;
    chk("no_bypass", bus.InstrOut, NOP);
    step();
    chk("imm_encode", bus.InstrOut, 32'h2861_00FF);
    chk("imm_valid", 32'(bus.out_valid), 32'd1);

    // Register encode; immediate must be ignored.
    drive(1'b1, 1'b0, 3'b001, 5'd2, 5'd4, 5'd5, 16'hFFFF);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("reg_encode", bus.InstrOut, 32'h0444_2800);
    step();

    // Fill under stall, refuse a fifth push, drain; three rounds cover pointer wrap.
    for (int r = 0; r < 3; r++) begin
      bus.stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
        drive_rand();
        step();
      end
      chk("full_count", 32'(bus.count), 32'd4);
      chk("full_ready", 32'(bus.in_ready), 32'd0);
      drive_rand();
      step();
      bus.stall    = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("drain_nop", bus.InstrOut, NOP);
      chk("drain_valid", 32'(bus.out_valid), 32'd0);
    end

    // Stall hold with B buffered behind A.
    drive(1'b1, 1'b1, 3'b101, 5'd7, 5'd8, 5'd0, 16'h1234);
    a_w = cur_word();
    step();
    drive(1'b1, 1'b0, 3'b110, 5'd9, 5'd10, 5'd11, 16'h0000);
    b_w = cur_word();
    step();
    bus.in_valid = 1'b0;
    bus.stall    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", bus.InstrOut, a_w);
    end
    bus.stall = 1'b0;
    step();
    chk("stall_release", bus.InstrOut, b_w);
    step();

    // Flush beats stall and a same-cycle push.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
    end
    chk("pre_flush_count", 32'(bus.count), 32'd3);
    drive(1'b1, 1'b1, 3'b111, 5'd31, 5'd31, 5'd0, 16'hBEEF);
    x_w       = cur_word();
    bus.flush = 1'b1;
    step();
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_instr", bus.InstrOut, NOP);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_dropped", 32'(bus.InstrOut == x_w), 32'd0);
    end

    // Reset mid-stream with count=2 and a valid word on InstrOut.
    drive_rand();
    step();
    drive_rand();
    step();
    bus.stall = 1'b1;
    drive_rand();
    step();
    chk("pre_rst_count", 32'(bus.count), 32'd2);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    rst          = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_instr", bus.InstrOut, NOP);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 1'b0, 3'b011, 5'd12, 5'd13, 5'd14, 16'h5555);
    w4 = cur_word();
    step();
    bus.in_valid = 1'b0;
    step();
    chk("post_rst_issue", bus.InstrOut, w4);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
